// File: rtl/ir_queue.sv
// ir_queue: instruction FIFO with registered head, opcode decode and sticky overflow.
// Revision 1.0
`default_nettype none

module ir_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int OPC_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            d_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            d_out,
  output logic [OPC_W-1:0]             opcode,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, full;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign d_out  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign opcode = d_out[DATA_W-1 -: OPC_W];
  assign count  = count_q;
  assign ovf    = ovf_q;

  // Flush wins over any push or pop presented in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (in_valid && full)  ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; only pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= d_in;
  end

endmodule

`default_nettype wire

// File: tb/tb_ir_queue.sv
// tb_ir_queue: table vectors, corner sequences and random traffic against a queue model.
`default_nettype none

module tb_ir_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] d_in;
  logic        in_ready, out_valid, ovf;
  logic [15:0] d_out;
  logic [3:0]  opcode;
  logic [2:0]  count;

  logic        flush2, in_valid2, out_ready2;
  logic [31:0] d_in2, d_out2;
  logic        in_ready2, out_valid2, ovf2;
  logic [5:0]  opcode2;
  logic [3:0]  count2;

  int checks = 0;
  int failures = 0;

  logic [15:0] mq[$];
  bit          movf;

  always #5 clk = ~clk;

  ir_queue #(.DATA_W(16), .DEPTH(4), .OPC_W(4)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out),
    .opcode(opcode), .count(count), .ovf(ovf)
  );

  ir_queue #(.DATA_W(32), .DEPTH(8), .OPC_W(6)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .d_in(d_in2), .out_valid(out_valid2), .out_ready(out_ready2), .d_out(d_out2),
    .opcode(opcode2), .count(count2), .ovf(ovf2)
  );

  typedef struct packed {
    logic        fl;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic [2:0]  cnt;
    logic        vld;
    logic [15:0] dout;
    logic        ov;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [15:0] hd;
    hd = (mq.size() != 0) ? mq[0] : 16'h0;
    chk("count", 32'(count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() != 4));
    chk("d_out", 32'(d_out), 32'(hd));
    chk("opcode", 32'(opcode), 32'(hd >> 12));
    chk("ovf", 32'(ovf), 32'(movf));
  endtask

  // Advance one clock, update the reference queue with the rules, then compare.
  task automatic tick();
    bit do_push, do_pop;
    @(posedge clk);
    do_push = in_valid && (mq.size() != 4);
    do_pop  = out_ready && (mq.size() != 0);
    if (flush) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      if (in_valid && mq.size() == 4) movf = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(d_in);
    end
    #1;
    check_model();
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [15:0] d, input logic ordy);
    flush = fl; in_valid = iv; d_in = d; out_ready = ordy;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 16'hA123, 1'b0, 3'd1, 1'b1, 16'hA123, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 16'h1111, 1'b0, 3'd1, 1'b1, 16'h1111, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 16'h2222, 1'b0, 3'd2, 1'b1, 16'h1111, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 16'h3333, 1'b0, 3'd3, 1'b1, 16'h1111, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 16'h4444, 1'b0, 3'd4, 1'b1, 16'h1111, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 16'h5555, 1'b0, 3'd4, 1'b1, 16'h1111, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b1, 16'h2222, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b1, 16'h3333, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b1, 16'h4444, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 16'h5555, 1'b0, 3'd1, 1'b1, 16'h5555, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 16'h6666, 1'b0, 3'd2, 1'b1, 16'h5555, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 16'h7777, 1'b0, 3'd3, 1'b1, 16'h5555, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 16'h8888, 1'b0, 3'd4, 1'b1, 16'h5555, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 16'h9999, 1'b1, 3'd3, 1'b1, 16'h6666, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 16'hAAAA, 1'b0, 3'd4, 1'b1, 16'h6666, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 16'hBBBB, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    flush2 = 1'b0; in_valid2 = 1'b0; d_in2 = '0; out_ready2 = 1'b0;
    movf = 1'b0;

    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_d_out", 32'(d_out), 32'd0);
    chk("reset_opcode", 32'(opcode), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // Directed vectors: first push, overflow, sticky ovf, pop-while-full, flush.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      tick();
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_dout", i), 32'(d_out), 32'(tbl[i].dout));
      chk($sformatf("tbl%0d_opcode", i), 32'(opcode), 32'(tbl[i].dout[15:12]));
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ov));
    end

    // Steady state at two entries while both pointers wrap.
    drive(1'b0, 1'b1, 16'h0C01, 1'b0); tick();
    drive(1'b0, 1'b1, 16'h0C02, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 16'(16'h0D00 + i), 1'b1);
      tick();
      chk("steady_count", 32'(count), 32'd2);
    end

    // Random traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0),
            16'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end

    // Asynchronous reset between edges with three entries queued.
    drive(1'b1, 1'b0, 16'h0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 16'(16'h3100 + i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_d_out", 32'(d_out), 32'd0);
    mq.delete();
    movf = 1'b0;
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 16'hE5E5, 1'b0);
    tick();
    chk("arst_new_head", 32'(d_out), 32'h0000E5E5);
    drive(1'b0, 1'b0, 16'h0, 1'b0);

    // Wide configuration: opcode extraction and fill to eight entries.
    in_valid2 = 1'b1;
    d_in2 = 32'hFC000001;
    @(posedge clk); #1;
    chk("w32_opcode", 32'(opcode2), 32'h3F);
    chk("w32_d_out", d_out2, 32'hFC000001);
    chk("w32_count1", 32'(count2), 32'd1);
    for (int i = 0; i < 7; i++) begin
      d_in2 = $urandom;
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    chk("w32_count8", 32'(count2), 32'd8);
    chk("w32_in_ready", 32'(in_ready2), 32'd0);
    chk("w32_head", d_out2, 32'hFC000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
